// File: rtl/debounce_timer_arbiter.sv
// debounce_timer_arbiter: debounces N_CH buttons with one shared delay counter.
// A round-robin arbiter lends the counter to one pending channel at a time; the
// channel's level is sampled once at the terminal count to confirm the change.
// Optional feature macro: DEBOUNCE_RELEASE_SHOT_EN adds a release_shot output
// that pulses when a release is confirmed.
// Handshake note: there is no valid/ready interface; each channel raises a
// pending request by entering a PEND state and holds it until its grant ends.
module debounce_timer_arbiter #(
  parameter int N_CH         = 4,
  parameter int DELAY_CYCLES = 300,
  localparam int CNT_W       = $clog2(DELAY_CYCLES),
  localparam int GW          = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] d_in,
  output logic [N_CH-1:0] one_shot,
`ifdef DEBOUNCE_RELEASE_SHOT_EN
  output logic [N_CH-1:0] release_shot,
`endif
  output logic            busy,
  output logic [GW-1:0]   grant_ch
);

  typedef enum logic [1:0] {
    CH_IDLE, CH_PEND_PRESS, CH_HELD, CH_PEND_REL
  } ch_state_t;

  typedef enum logic {
    ARB_IDLE, TIMING
  } arb_state_t;

  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] d_sync;
  ch_state_t       ch_state [N_CH];
  ch_state_t       ch_next  [N_CH];
  arb_state_t      arb_state;
  arb_state_t      arb_next;
  logic [CNT_W-1:0] counter;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   idx;
  logic [GW:0]     sum;
  logic            found;
  logic [N_CH-1:0] pend;
  logic            tc;
  logic [N_CH-1:0] shot_next;
`ifdef DEBOUNCE_RELEASE_SHOT_EN
  logic [N_CH-1:0] rel_next;
`endif

  // Terminal count: last cycle of the current grant's verification window.
  assign tc       = (arb_state == TIMING) && (counter == CNT_W'(DELAY_CYCLES - 1));
  assign busy     = (arb_state == TIMING);
  assign grant_ch = grant;

  // Pending flags and round-robin pick of the first pending channel from rr_ptr.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      pend[i] = (ch_state[i] == CH_PEND_PRESS) || (ch_state[i] == CH_PEND_REL);
    end
    for (int k = 0; k < N_CH; k++) begin
      sum = {1'b0, rr_ptr} + (GW+1)'(k);
      if (sum >= (GW+1)'(N_CH)) sum = sum - (GW+1)'(N_CH);
      idx = sum[GW-1:0];
      if (!found && pend[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Arbiter next state: grant when anything is pending, release at terminal count.
  always_comb begin
    arb_next = arb_state;
    case (arb_state)
      ARB_IDLE: if (found) arb_next = TIMING;
      TIMING:   if (tc)    arb_next = ARB_IDLE;
      default:  arb_next = ARB_IDLE;
    endcase
  end

  // Per-channel next state; only the granted channel at terminal count resolves.
  always_comb begin
    shot_next = '0;
`ifdef DEBOUNCE_RELEASE_SHOT_EN
    rel_next  = '0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      ch_next[i] = ch_state[i];
      case (ch_state[i])
        CH_IDLE: if (d_sync[i]) ch_next[i] = CH_PEND_PRESS;
        CH_PEND_PRESS: begin
          if (tc && (grant == GW'(i))) begin
            if (d_sync[i]) begin
              ch_next[i]   = CH_HELD;
              shot_next[i] = 1'b1;
            end else begin
              ch_next[i]   = CH_IDLE;
            end
          end
        end
        CH_HELD: if (!d_sync[i]) ch_next[i] = CH_PEND_REL;
        CH_PEND_REL: begin
          if (tc && (grant == GW'(i))) begin
            if (!d_sync[i]) begin
              ch_next[i]  = CH_IDLE;
`ifdef DEBOUNCE_RELEASE_SHOT_EN
              rel_next[i] = 1'b1;
`endif
            end else begin
              ch_next[i]  = CH_HELD;
            end
          end
        end
        default: ch_next[i] = CH_IDLE;
      endcase
    end
  end

  // State registers, synchronizers, shared counter and registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      d_sync    <= '0;
      arb_state <= ARB_IDLE;
      counter   <= '0;
      rr_ptr    <= '0;
      grant     <= '0;
      one_shot  <= '0;
`ifdef DEBOUNCE_RELEASE_SHOT_EN
      release_shot <= '0;
`endif
      for (int i = 0; i < N_CH; i++) ch_state[i] <= CH_IDLE;
    end else begin
      sync1     <= d_in;
      d_sync    <= sync1;
      arb_state <= arb_next;
      one_shot  <= shot_next;
`ifdef DEBOUNCE_RELEASE_SHOT_EN
      release_shot <= rel_next;
`endif
      for (int i = 0; i < N_CH; i++) ch_state[i] <= ch_next[i];
      if (arb_state == ARB_IDLE) begin
        if (found) begin
          grant   <= pick;
          counter <= '0;
        end
      end else if (tc) begin
        rr_ptr <= (grant == GW'(N_CH - 1)) ? '0 : grant + GW'(1);
        grant  <= '0;
      end else begin
        counter <= counter + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Bench for debounce_timer_arbiter with N_CH=4, DELAY_CYCLES=8.
// A behavioural model (confirmed level + pending flag per channel, an owner
// index with a countdown) is compared against the DUT every cycle; a vector
// table and hand sequences check pulse timing, grants and reset behaviour.
module tb_debounce_timer_arbiter;
  localparam int N = 4;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d_in = 4'h0;
  logic [3:0] one_shot;
  logic       busy;
  logic [1:0] grant_ch;
`ifdef DEBOUNCE_RELEASE_SHOT_EN
  logic [3:0] release_shot;
`endif

  int vectors = 0;
  int miscompares = 0;

  debounce_timer_arbiter #(.N_CH(N), .DELAY_CYCLES(D)) dut (
    .clk(clk),
    .rst(rst),
    .d_in(d_in),
    .one_shot(one_shot),
`ifdef DEBOUNCE_RELEASE_SHOT_EN
    .release_shot(release_shot),
`endif
    .busy(busy),
    .grant_ch(grant_ch)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model state
  logic [3:0] m_s1 = '0, m_ds = '0, m_conf = '0, m_pend = '0, m_shot = '0, m_rel = '0;
  int m_owner = -1, m_left = 0, m_rr = 0;
  logic [3:0] n_conf, n_pend, n_shot, n_rel;
  int n_owner, n_left, n_rr, c;

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_ds = '0; m_conf = '0; m_pend = '0; m_shot = '0; m_rel = '0;
      m_owner = -1; m_left = 0; m_rr = 0;
    end else begin
      n_conf = m_conf; n_pend = m_pend; n_shot = '0; n_rel = '0;
      n_owner = m_owner; n_left = m_left; n_rr = m_rr;
      if (m_owner >= 0) begin
        n_left = m_left - 1;
        if (n_left == 0) begin
          if (m_ds[m_owner] != m_conf[m_owner]) begin
            n_conf[m_owner] = m_ds[m_owner];
            if (m_ds[m_owner]) n_shot[m_owner] = 1'b1;
            else               n_rel[m_owner]  = 1'b1;
          end
          n_pend[m_owner] = 1'b0;
          n_rr = (m_owner + 1) % N;
          n_owner = -1;
        end
      end else if (|m_pend) begin
        for (int k = 0; k < N; k++) begin
          c = (m_rr + k) % N;
          if (n_owner < 0 && m_pend[c]) begin
            n_owner = c;
            n_left = D;
          end
        end
      end
      for (int i = 0; i < N; i++)
        if (!m_pend[i] && (m_ds[i] != m_conf[i])) n_pend[i] = 1'b1;
      m_ds = m_s1; m_s1 = d_in;
      m_conf = n_conf; m_pend = n_pend; m_shot = n_shot; m_rel = n_rel;
      m_owner = n_owner; m_left = n_left; m_rr = n_rr;
    end
  end

  // Segment observations
  logic [3:0]  seg_mask, seg_gseen;
  int          seg_total, seg_first, tix;
  int          ch_tick [4];
  logic [63:0] busy_trace;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("one_shot_vs_model", 32'(one_shot), 32'(m_shot));
    check("busy_vs_model", 32'(busy), 32'(m_owner >= 0));
    check("grant_vs_model", 32'(grant_ch), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check("one_shot_onehot", 32'($countones(one_shot) <= 1), 32'd1);
`ifdef DEBOUNCE_RELEASE_SHOT_EN
    check("release_vs_model", 32'(release_shot), 32'(m_rel));
`endif
    seg_mask  |= one_shot;
    seg_total += $countones(one_shot);
    if ((|one_shot) && seg_first < 0) seg_first = tix;
    for (int i = 0; i < N; i++) if (one_shot[i] && ch_tick[i] < 0) ch_tick[i] = tix;
    if (busy) seg_gseen[grant_ch] = 1'b1;
    if (tix < 64) busy_trace[tix] = busy;
    tix++;
  endtask

  task automatic run(input logic r, input logic [3:0] din, input int n);
    rst = r; d_in = din;
    seg_mask = '0; seg_gseen = '0; seg_total = 0; seg_first = -1; tix = 0;
    busy_trace = '0;
    for (int i = 0; i < N; i++) ch_tick[i] = -1;
    repeat (n) tick();
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] din;
    int         cycles;
    logic [3:0] exp_mask;
    int         exp_total;
    int         exp_first;
    logic [3:0] exp_gseen;
    logic       exp_busy;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // rst, din, cycles, pulse mask, pulse count, first pulse tick, grants seen, busy at end
    tbl[0]  = '{1'b1, 4'h0,  3, 4'h0, 0, -1, 4'h0, 1'b0};  // reset
    tbl[1]  = '{1'b0, 4'h2,  3, 4'h0, 0, -1, 4'h0, 1'b0};  // ch1 glitch
    tbl[2]  = '{1'b0, 4'h0, 20, 4'h0, 0, -1, 4'h2, 1'b0};  // glitch rejected
    tbl[3]  = '{1'b0, 4'h4, 20, 4'h4, 1, 11, 4'h4, 1'b0};  // ch2 press
    tbl[4]  = '{1'b0, 4'h0,  2, 4'h0, 0, -1, 4'h0, 1'b0};  // ch2 release bounce
    tbl[5]  = '{1'b0, 4'h4, 20, 4'h0, 0, -1, 4'h4, 1'b0};  // back to held, silent
    tbl[6]  = '{1'b0, 4'h0, 20, 4'h0, 0, -1, 4'h4, 1'b0};  // real release
    tbl[7]  = '{1'b0, 4'h8,  6, 4'h0, 0, -1, 4'h8, 1'b1};  // ch3 press, timing
    tbl[8]  = '{1'b1, 4'h8,  1, 4'h0, 0, -1, 4'h0, 1'b0};  // reset mid-grant
    tbl[9]  = '{1'b0, 4'h8, 20, 4'h8, 1, 11, 4'h8, 1'b0};  // re-press
    tbl[10] = '{1'b0, 4'h0, 20, 4'h0, 0, -1, 4'h8, 1'b0};  // release

    for (int v = 0; v < 11; v++) begin
      run(tbl[v].rst, tbl[v].din, tbl[v].cycles);
      check($sformatf("row%0d_mask", v),  32'(seg_mask),  32'(tbl[v].exp_mask));
      check($sformatf("row%0d_count", v), 32'(seg_total), 32'(tbl[v].exp_total));
      check($sformatf("row%0d_first", v), 32'(seg_first), 32'(tbl[v].exp_first));
      check($sformatf("row%0d_grants", v), 32'(seg_gseen), 32'(tbl[v].exp_gseen));
      check($sformatf("row%0d_busy", v),  32'(busy),      32'(tbl[v].exp_busy));
    end

    // Reset with all buttons held, then contention after release of reset
    run(1'b1, 4'hF, 3);
    check("reset_one_shot", 32'(one_shot), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_grant", 32'(grant_ch), 32'd0);
    run(1'b0, 4'hF, 45);
    check("contend_count", 32'(seg_total), 32'd4);
    check("contend_ch0", 32'(ch_tick[0]), 32'd11);
    check("contend_ch1", 32'(ch_tick[1]), 32'd20);
    check("contend_ch2", 32'(ch_tick[2]), 32'd29);
    check("contend_ch3", 32'(ch_tick[3]), 32'd38);
    run(1'b0, 4'h0, 40);
    check("release_all_quiet", 32'(seg_total), 32'd0);

    // Clean press on ch0: one pulse after edge 11, busy on edges 3..10
    run(1'b0, 4'h1, 60);
    check("press_count", 32'(seg_total), 32'd1);
    check("press_tick", 32'(ch_tick[0]), 32'd11);
    check("press_busy_trace", busy_trace[31:0], 32'h0000_07F8);
    run(1'b0, 4'h0, 20);

    // Randomized stimulus against the model
    for (int r = 0; r < 40; r++) begin
      run(($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)), $urandom_range(1, 25));
    end
    run(1'b0, 4'h0, 60);
    check("drain_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
